// File: rtl/audio_cap_pkg.sv
// rtl/audio_cap_pkg.sv - shared types and constants for the audio capture controller
//
// Purpose: capture state encoding, channel-select codes, default frame length
// and the stereo averaging helper used by the sample selector.
// Ports: none (package).
package audio_cap_pkg;

  localparam int FRAME_LEN_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FILL  = 2'd2,
    ST_READY = 2'd3
  } cap_state_e;

  // Code 2'b11 is not listed here; it falls back to the left channel.
  localparam logic [1:0] CH_LEFT  = 2'b00;
  localparam logic [1:0] CH_RIGHT = 2'b01;
  localparam logic [1:0] CH_AVG   = 2'b10;

  // Sign-extend both channels into a 17-bit sum, then drop the LSB
  // (arithmetic shift right by one, truncated back to 16 bits).
  function automatic logic [15:0] avg_sample(input logic [15:0] l, input logic [15:0] r);
    logic [16:0] sum;
    sum = {l[15], l} + {r[15], r};
    return sum[16:1];
  endfunction

endpackage

// File: rtl/audio_sample_sel.sv
// rtl/audio_sample_sel.sv - registered channel selector / averager
//
// Purpose: picks left, right or the mono average out of a 32-bit stereo FIFO
// word and registers it (one cycle of latency).
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   en_i         - load a new sample this cycle
//   sel_i        - channel select code (see audio_cap_pkg)
//   word_i       - {left[15:0], right[15:0]}, two's complement
//   sample_o     - registered selected sample
module audio_sample_sel
  import audio_cap_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [1:0]  sel_i,
  input  logic [31:0] word_i,
  output logic [15:0] sample_o
);

  logic [15:0] sample_d;
  logic [15:0] sample_q;

  always_comb begin
    sample_d = word_i[31:16];
    case (sel_i)
      CH_RIGHT: sample_d = word_i[15:0];
      CH_AVG:   sample_d = avg_sample(word_i[31:16], word_i[15:0]);
      default:  sample_d = word_i[31:16];
    endcase
  end

  // Holding the value between loads keeps buf_wdata at the last written sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= 16'd0;
    end else if (en_i) begin
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/audio_capture_ctrl.sv
// rtl/audio_capture_ctrl.sv - ADC FIFO to frame-buffer capture controller
//
// Purpose: on start, clears the ADC path, then reads FRAME_LEN stereo words
// from the ADC FIFO, writes the selected channel into a frame buffer and
// flags frame_ready until the consumer acknowledges. In continuous mode,
// samples arriving while the frame is held are read and discarded (counted
// in drop_count) and the next frame starts straight after frame_ack.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start, continuous     - arm a capture / re-arm after each acked frame
//   ch_sel                - channel select, latched on entry to a frame
//   adc_read/readdata/empty/clear - ADC FIFO interface (data one cycle after read)
//   buf_we/addr/wdata     - frame-buffer write port
//   frame_ready/frame_ack - frame handshake with the consumer
//   busy, drop_count      - status
module audio_capture_ctrl
  import audio_cap_pkg::*;
#(
  parameter int FRAME_LEN    = FRAME_LEN_DEFAULT,
  parameter int ADDR_W       = 10,
  parameter int CLEAR_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [1:0]        ch_sel,
  output logic              adc_read,
  input  logic [31:0]       adc_readdata,
  input  logic              adc_empty,
  output logic              adc_clear,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [15:0]       buf_wdata,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              busy,
  output logic [15:0]       drop_count
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [ADDR_W:0]  LEN_CNT  = (ADDR_W + 1)'(FRAME_LEN);
  localparam logic [ADDR_W:0]  LAST_WR  = (ADDR_W + 1)'(FRAME_LEN - 1);

  cap_state_e       state_q;
  logic [1:0]       ch_sel_q;
  logic [CLR_W-1:0] clr_cnt_q;
  logic [ADDR_W:0]  iss_cnt_q;
  logic [ADDR_W:0]  wr_cnt_q;
  logic             rd_v1_q;      // a buffer read was issued last cycle; its data is on adc_readdata now
  logic             we_q;
  logic             adc_clear_q;
  logic             frame_ready_q;
  logic [15:0]      drop_q;
  logic [15:0]      drop_d;
  logic             fill_rd;
  logic             drop_rd;

  assign fill_rd = (state_q == ST_FILL) && !adc_empty && (iss_cnt_q < LEN_CNT);
  assign drop_rd = (state_q == ST_READY) && continuous && !adc_empty;
  assign drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

  // Gated by reset so nothing is pulled from the FIFO while the block is being reset.
  assign adc_read = !reset && (fill_rd || drop_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ch_sel_q      <= CH_LEFT;
      clr_cnt_q     <= '0;
      iss_cnt_q     <= '0;
      wr_cnt_q      <= '0;
      rd_v1_q       <= 1'b0;
      we_q          <= 1'b0;
      adc_clear_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      drop_q        <= 16'd0;
    end else begin
      // Only reads issued in FILL turn into writes; discard reads never reach the buffer.
      rd_v1_q <= fill_rd;
      we_q    <= rd_v1_q;
      if (fill_rd) iss_cnt_q <= iss_cnt_q + 1'b1;
      if (we_q)    wr_cnt_q  <= wr_cnt_q + 1'b1;
      if (drop_rd) drop_q    <= drop_d;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_CLEAR;
            adc_clear_q <= 1'b1;
            clr_cnt_q   <= '0;
            drop_q      <= 16'd0;
            ch_sel_q    <= ch_sel;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_q     <= ST_FILL;
            adc_clear_q <= 1'b0;
            iss_cnt_q   <= '0;
            wr_cnt_q    <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        ST_FILL: begin
          // All reads were issued at least two cycles earlier, so none is in flight here.
          if (we_q && (wr_cnt_q == LAST_WR)) begin
            state_q       <= ST_READY;
            frame_ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          if (frame_ack) begin
            frame_ready_q <= 1'b0;
            if (continuous) begin
              state_q   <= ST_FILL;
              ch_sel_q  <= ch_sel;
              iss_cnt_q <= '0;
              wr_cnt_q  <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  audio_sample_sel u_sample_sel (
    .clk      (clk),
    .reset    (reset),
    .en_i     (rd_v1_q),
    .sel_i    (ch_sel_q),
    .word_i   (adc_readdata),
    .sample_o (buf_wdata)
  );

  assign adc_clear   = adc_clear_q;
  assign buf_we      = we_q;
  assign buf_addr    = wr_cnt_q[ADDR_W-1:0];
  assign frame_ready = frame_ready_q;
  assign busy        = (state_q != ST_IDLE);
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_audio_capture_ctrl.sv
// tb/tb_audio_capture_ctrl.sv - self-checking bench for audio_capture_ctrl
module tb_audio_capture_ctrl;

  localparam int FL = 16;
  localparam int AW = 4;
  localparam int CC = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic [1:0]    ch_sel = 2'b00;
  logic          adc_read;
  logic [31:0]   adc_readdata = 32'd0;
  logic          adc_empty = 1'b0;
  logic          adc_clear;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [15:0]   buf_wdata;
  logic          frame_ready;
  logic          frame_ack = 1'b0;
  logic          busy;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  audio_capture_ctrl #(.FRAME_LEN(FL), .ADDR_W(AW), .CLEAR_CYCLES(CC)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .ch_sel(ch_sel),
    .adc_read(adc_read), .adc_readdata(adc_readdata), .adc_empty(adc_empty),
    .adc_clear(adc_clear), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .frame_ready(frame_ready), .frame_ack(frame_ack), .busy(busy), .drop_count(drop_count)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  // Reference model: phase 0 idle, 1 clear, 2 fill, 3 ready.
  int          ph = 0;
  int          clr_n = 0;
  int          issued = 0;
  int          written = 0;
  int          drop = 0;
  logic [1:0]  msel = 2'b00;
  int          due_q[$];
  logic [15:0] samp_q[$];
  logic [31:0] dir_q[$];
  int          empty_mode = 0;
  logic [15:0] got[3];
  int          got_n = 0;
  int          nwr = 0;
  int          s_cyc;

  function automatic logic [15:0] pick(input logic [1:0] s, input logic [31:0] w);
    int l, r, a;
    l = int'($signed(w[31:16]));
    r = int'($signed(w[15:0]));
    a = (l + r) >>> 1;
    case (s)
      2'b01:   return w[15:0];
      2'b10:   return a[15:0];
      default: return w[31:16];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic cyc();
    logic        exp_read, exp_we, cur_fill;
    logic [31:0] w;
    #1;
    exp_read = !reset && ((ph == 2 && !adc_empty && issued < FL) ||
                          (ph == 3 && continuous && !adc_empty));
    exp_we = (due_q.size() > 0) && (due_q[0] == cycle);
    chk("adc_read", {31'd0, adc_read}, {31'd0, exp_read});
    chk("adc_clear", {31'd0, adc_clear}, (ph == 1) ? 32'd1 : 32'd0);
    chk("frame_ready", {31'd0, frame_ready}, (ph == 3) ? 32'd1 : 32'd0);
    chk("busy", {31'd0, busy}, (ph != 0) ? 32'd1 : 32'd0);
    chk("buf_we", {31'd0, buf_we}, {31'd0, exp_we});
    chk("drop_count", {16'd0, drop_count}, 32'(drop));
    if (exp_we) begin
      chk("buf_addr", {28'd0, buf_addr}, 32'(written));
      if (samp_q.size() > 0) chk("buf_wdata", {16'd0, buf_wdata}, {16'd0, samp_q[0]});
      if (got_n < 3) begin
        got[got_n] = buf_wdata;
        got_n++;
      end
      nwr++;
      due_q.delete(0);
      if (samp_q.size() > 0) samp_q.delete(0);
    end
    cur_fill = exp_read && (ph == 2);
    if (reset) begin
      ph = 0; drop = 0; msel = 2'b00; issued = 0; written = 0;
      due_q.delete(); samp_q.delete();
    end else begin
      case (ph)
        0: if (start) begin ph = 1; clr_n = 0; drop = 0; msel = ch_sel; end
        1: begin
          clr_n++;
          if (clr_n == CC) begin ph = 2; issued = 0; written = 0; end
        end
        2: begin
          if (exp_read) begin issued++; due_q.push_back(cycle + 2); end
          if (exp_we) begin
            written++;
            if (written == FL) ph = 3;
          end
        end
        default: begin
          if (exp_read && drop < 65535) drop++;
          if (frame_ack) begin
            if (continuous) begin ph = 2; msel = ch_sel; issued = 0; written = 0; end
            else ph = 0;
          end
        end
      endcase
    end
    @(posedge clk);
    cycle++;
    #1;
    w = $urandom;
    if (cur_fill) begin
      if (dir_q.size() > 0) begin
        w = dir_q[0];
        dir_q.delete(0);
      end
      samp_q.push_back(pick(msel, w));
    end
    adc_readdata = w;
    case (empty_mode)
      0:       adc_empty = 1'b0;
      1:       adc_empty = ~adc_empty;
      default: adc_empty = ($urandom_range(0, 3) == 0);
    endcase
  endtask

  task automatic run_to_ready(input bit rand_sel);
    for (int i = 0; i < 400 && !frame_ready; i++) begin
      if (rand_sel) ch_sel = 2'($urandom);
      cyc();
    end
    chk("reach_ready", {31'd0, frame_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc();
    reset = 1'b0;
    chk("rst_addr", {28'd0, buf_addr}, 32'd0);
    chk("rst_wdata", {16'd0, buf_wdata}, 32'd0);
    chk("rst_drop", {16'd0, drop_count}, 32'd0);
    cyc();

    // Basic frame: clear length, back-to-back reads, ready latency.
    start = 1'b1; s_cyc = cycle;
    cyc();
    start = 1'b0;
    run_to_ready(1'b0);
    chk("ready_latency", 32'(cycle - s_cyc), 32'd35);
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
    chk("ack_idle", {31'd0, busy}, 32'd0);

    // Averaging corner words.
    ch_sel = 2'b10;
    dir_q.push_back(32'h7FFF_7FFF);
    dir_q.push_back(32'h8000_8000);
    dir_q.push_back(32'h0003_FFFF);
    start = 1'b1; cyc(); start = 1'b0;
    got_n = 0;
    run_to_ready(1'b1);
    chk("avg0", {16'd0, got[0]}, 32'h7FFF);
    chk("avg1", {16'd0, got[1]}, 32'h8000);
    chk("avg2", {16'd0, got[2]}, 32'h0001);
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;

    // Toggling empty flag.
    ch_sel = 2'b01; empty_mode = 1;
    start = 1'b1; cyc(); start = 1'b0;
    nwr = 0;
    run_to_ready(1'b0);
    chk("fill_writes", 32'(nwr), 32'd16);
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;

    // Continuous mode: 40 discard reads while waiting, refill without clear.
    empty_mode = 0; continuous = 1'b1; ch_sel = 2'b11;
    start = 1'b1; cyc(); start = 1'b0;
    run_to_ready(1'b0);
    repeat (39) cyc();
    ch_sel = 2'b10;
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
    chk("drop_40", {16'd0, drop_count}, 32'd40);
    chk("refill_clear", {31'd0, adc_clear}, 32'd0);
    chk("refill_addr", {28'd0, buf_addr}, 32'd0);
    run_to_ready(1'b0);
    continuous = 1'b0;
    repeat (3) cyc();
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;

    // start together with frame_ack in READY is ignored.
    start = 1'b1; cyc(); start = 1'b0;
    run_to_ready(1'b0);
    start = 1'b1; frame_ack = 1'b1; cyc(); start = 1'b0; frame_ack = 1'b0;
    chk("start_ack_busy", {31'd0, busy}, 32'd0);
    chk("start_ack_drop", {16'd0, drop_count}, 32'd0);
    cyc();
    chk("start_ack_noclr", {31'd0, adc_clear}, 32'd0);

    // Reset in the middle of FILL.
    ch_sel = 2'b00;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 100 && !(ph == 2 && written == 5); i++) cyc();
    chk("mid_addr5", {28'd0, buf_addr}, 32'd5);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_we", {31'd0, buf_we}, 32'd0);
    chk("mrst_addr", {28'd0, buf_addr}, 32'd0);
    chk("mrst_wdata", {16'd0, buf_wdata}, 32'd0);
    chk("mrst_read", {31'd0, adc_read}, 32'd0);
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_clear", {31'd0, adc_clear}, 32'd1);
    run_to_ready(1'b0);
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;

    // Randomised frames: random empty pattern, select, ack delay, mode.
    empty_mode = 2;
    continuous = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    for (int f = 0; f < 4; f++) begin
      run_to_ready(1'b1);
      for (int d = $urandom_range(0, 12); d > 0; d--) begin
        start = ($urandom_range(0, 3) == 0);
        cyc();
      end
      start = 1'b0;
      continuous = (f < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
      if (!continuous) begin
        continuous = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
      end
    end
    repeat (5) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
